dm_port_arbiter: RTL and testbench
==================================

Name: dm_port_arbiter

Overview:
- Shares one single-port 512x16 data SRAM among pipeline 0 (p0) and pipeline 1 (p1) memory stages, plus a low-priority external loader/debug port (ext).
- Same-cycle p0/p1 accesses are serialized in program order: p0 first, then p1.
- The stall output goes to the HCU, which freezes both pipelines while an access is deferred.
- Sits between the cpu top level's p0_DM_*/p1_DM_* buses and the data memory macro.

Parameters:
AW, 9, address width
DW, 16, data width
STARVE_MAX, 4, consecutive denied ext cycles before ext is forced a slot

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
p0_req  input  1  p0 memory access this cycle
p0_we  input  1  p0 write (1) / read (0)
p0_addr  input  AW  p0 address
p0_wdata  input  DW  p0 write data
p0_rdata  output  DW  p0 read data, registered
p1_req  input  1  p1 memory access this cycle
p1_we  input  1  p1 write / read
p1_addr  input  AW  p1 address
p1_wdata  input  DW  p1 write data
p1_rdata  output  DW  p1 read data, registered
ext_req  input  1  external access request, held until ack
ext_we  input  1  external write / read
ext_addr  input  AW  external address
ext_wdata  input  DW  external write data
ext_ack  output  1  one-cycle pulse: ext access issued this cycle
ext_rvalid  output  1  one-cycle pulse: ext_rdata valid
ext_rdata  output  DW  external read data
mem_addr  output  AW  SRAM address
mem_wdata  output  DW  SRAM write data
mem_we  output  1  SRAM write enable
mem_rdata  input  DW  SRAM read data, valid one cycle after address
stall  output  1  freeze both pipelines this cycle (combinational)

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, starve counter=0, held p1 request cleared.
  - p0_rdata, p1_rdata, ext_rdata = 0; ext_ack=0, ext_rvalid=0.
  - mem_we=0; stall=0 is forced while reset is asserted.
- Memory timing: address/we/wdata driven combinationally in cycle T; read data sampled from mem_rdata at the end of T+1 into the requester's rdata register.
- Each rdata register holds its value until that requester's next read completes.
- Write cycles do not alter rdata.
- State IDLE, decisions in priority order:
  1. ext_req=1 and starve==STARVE_MAX:
     - Grant ext; ext_ack=1.
     - stall=1 if p0_req or p1_req is high; the pipelines re-present those requests next cycle.
     - Counter resets to 0.
  2. p0_req=1 and p1_req=1:
     - Grant p0.
     - Latch p1 we/addr/wdata into the hold register; stall=1.
     - Next state HOLD_P1.
  3. Exactly one of p0_req or p1_req:
     - Grant that requester; stall=0.
  4. Only ext_req:
     - Grant ext; ext_ack=1; counter resets to 0.
  5. Nothing requested: mem_we=0, mem_addr=0.
- State HOLD_P1:
  - Issue the latched p1 access; stall=0.
  - Live p0/p1 requests are ignored: they are the same frozen instructions.
  - Next state IDLE.
  - ext is never granted in this state.
- Starve counter:
  - Increments each cycle ext_req=1 and ext is not granted.
  - Saturates at STARVE_MAX; clears on ext grant.
- Ordering consequences, all required:
  - Same-cycle p0 write / p1 read to the same address returns the new data to p1.
  - p0 read / p1 write returns the old data to p0.
  - Double write to the same address leaves the p1 data.
- ext_rvalid pulses one cycle after an ext read ack, together with ext_rdata update; it never pulses for an ext write.
- Reset during HOLD_P1 discards the latched p1 access; no SRAM write is issued for it.
- stall is asserted for at most one cycle per conflict; a new conflict cannot start in HOLD_P1.

Test Plan:
1. Reset, then p0 read addr 0x010 (mem holds 0x1234), p1 idle -> stall=0, p0_rdata=0x1234 one cycle after the request, p1_rdata stays 0.
2. Same cycle: p0 write 0x020<-0xBEEF, p1 read 0x020 -> stall=1 for one cycle; p0 write issued in cycle T; p1 read issued in T+1; p1_rdata=0xBEEF at T+2.
3. Same cycle: p0 write 0x030<-0x1111, p1 write 0x030<-0x2222 -> two consecutive mem_we cycles in p0-then-p1 order; final mem[0x030]=0x2222.
4. ext_req held with a read of 0x040 while p0_req is high for 4 cycles -> starve counts 1..4; 5th cycle ext_ack=1, stall=1, mem_addr=0x040; ext_rvalid=1 next cycle with ext_rdata=mem[0x040]; the p0 request is issued the cycle after the forced slot.
5. Conflict in cycle T, rst pulsed low during HOLD_P1 -> all outputs 0 immediately, no mem_we for the held p1 write, state IDLE after release.
6. ext write 0x050<-0xCAFE with no pipeline traffic -> ext_ack=1 the same cycle, mem_we=1, ext_rvalid stays 0.

Source files
------------

// File: rtl/dm_port_arbiter_if.sv
// Bus bundle between the two pipeline memory stages, the external loader port
// and the data SRAM macro, as seen by dm_port_arbiter.
interface dm_port_arbiter_if #(
  parameter int AW = 9,
  parameter int DW = 16
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic [DW-1:0] p1_rdata;

  logic          ext_req;
  logic          ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic          ext_ack;
  logic          ext_rvalid;
  logic [DW-1:0] ext_rdata;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  logic          stall;

  // Arbiter side
  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_rdata,
    input  ext_req, ext_we, ext_addr, ext_wdata,
    output ext_ack, ext_rvalid, ext_rdata,
    output mem_addr, mem_wdata, mem_we,
    input  mem_rdata,
    output stall
  );

  // Requester / memory-macro side
  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_rdata,
    output ext_req, ext_we, ext_addr, ext_wdata,
    input  ext_ack, ext_rvalid, ext_rdata,
    input  mem_addr, mem_wdata, mem_we,
    output mem_rdata,
    input  stall
  );
endinterface

// File: rtl/dm_port_arbiter.sv
// Single-port data SRAM arbiter: p0 and p1 serialized in program order (p0 first),
// external loader port served when idle or when it has starved STARVE_MAX cycles.
module dm_port_arbiter #(
  parameter int AW         = 9,
  parameter int DW         = 16,
  parameter int STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst,
  dm_port_arbiter_if.slave bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  typedef enum logic {IDLE, HOLD_P1} state_t;
  typedef enum logic [1:0] {SRC_NONE, SRC_P0, SRC_P1, SRC_EXT} src_t;

  state_t        state, state_nx;
  logic [SW-1:0] starve, starve_nx;
  logic          starve_full;

  logic          hold_we;
  logic [AW-1:0] hold_addr;
  logic [DW-1:0] hold_wdata;
  logic          hold_load;

  src_t          grant;
  logic          use_hold;
  logic          stall_c;
  logic          acc_we;
  logic [AW-1:0] acc_addr;
  logic [DW-1:0] acc_wdata;

  src_t          rd_src;
  logic [DW-1:0] p0_rdata_q, p1_rdata_q, ext_rdata_q;
  logic          ext_rvalid_q;

  assign starve_full = (starve == SW'(STARVE_MAX));

  always_comb begin
    state_nx  = state;
    starve_nx = starve;
    grant     = SRC_NONE;
    use_hold  = 1'b0;
    hold_load = 1'b0;
    stall_c   = 1'b0;
    case (state)
      // The pipelines are frozen, so live p0/p1 requests repeat the deferred ones.
      HOLD_P1: begin
        grant    = SRC_P1;
        use_hold = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        if (bus.ext_req && starve_full) begin
          grant   = SRC_EXT;
          stall_c = bus.p0_req | bus.p1_req;
        end else if (bus.p0_req && bus.p1_req) begin
          grant     = SRC_P0;
          hold_load = 1'b1;
          stall_c   = 1'b1;
          state_nx  = HOLD_P1;
        end else if (bus.p0_req) begin
          grant = SRC_P0;
        end else if (bus.p1_req) begin
          grant = SRC_P1;
        end else if (bus.ext_req) begin
          grant = SRC_EXT;
        end
      end
    endcase
    if (grant == SRC_EXT) begin
      starve_nx = '0;
    end else if (bus.ext_req && !starve_full) begin
      starve_nx = starve + SW'(1);
    end
  end

  always_comb begin
    acc_we    = 1'b0;
    acc_addr  = '0;
    acc_wdata = '0;
    case (grant)
      SRC_P0: begin
        acc_we    = bus.p0_we;
        acc_addr  = bus.p0_addr;
        acc_wdata = bus.p0_wdata;
      end
      SRC_P1: begin
        acc_we    = use_hold ? hold_we    : bus.p1_we;
        acc_addr  = use_hold ? hold_addr  : bus.p1_addr;
        acc_wdata = use_hold ? hold_wdata : bus.p1_wdata;
      end
      SRC_EXT: begin
        acc_we    = bus.ext_we;
        acc_addr  = bus.ext_addr;
        acc_wdata = bus.ext_wdata;
      end
      default: ;
    endcase
  end

  // Combinational outputs are forced quiet while reset is held, so a held p1 write dies.
  assign bus.mem_we    = rst & acc_we;
  assign bus.mem_addr  = rst ? acc_addr  : '0;
  assign bus.mem_wdata = rst ? acc_wdata : '0;
  assign bus.ext_ack   = rst & (grant == SRC_EXT);
  assign bus.stall     = rst & stall_c;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve     <= '0;
      hold_we    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
      rd_src     <= SRC_NONE;
    end else begin
      state  <= state_nx;
      starve <= starve_nx;
      if (hold_load) begin
        hold_we    <= bus.p1_we;
        hold_addr  <= bus.p1_addr;
        hold_wdata <= bus.p1_wdata;
      end
      rd_src <= (grant != SRC_NONE && !acc_we) ? grant : SRC_NONE;
    end
  end

  // Read data is valid the cycle after the address; ext_rvalid rises with ext_rdata.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p0_rdata_q   <= '0;
      p1_rdata_q   <= '0;
      ext_rdata_q  <= '0;
      ext_rvalid_q <= 1'b0;
    end else begin
      ext_rvalid_q <= (rd_src == SRC_EXT);
      case (rd_src)
        SRC_P0:  p0_rdata_q  <= bus.mem_rdata;
        SRC_P1:  p1_rdata_q  <= bus.mem_rdata;
        SRC_EXT: ext_rdata_q <= bus.mem_rdata;
        default: ;
      endcase
    end
  end

  assign bus.p0_rdata   = p0_rdata_q;
  assign bus.p1_rdata   = p1_rdata_q;
  assign bus.ext_rdata  = ext_rdata_q;
  assign bus.ext_rvalid = ext_rvalid_q;

  a_no_ext_in_hold: assert property (@(posedge clk) disable iff (!rst)
    (state == HOLD_P1) |-> !bus.ext_ack);
  a_starve_bounded: assert property (@(posedge clk) disable iff (!rst)
    starve <= SW'(STARVE_MAX));

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Bench for dm_port_arbiter: SRAM model, rule-level reference model checked every
// cycle on the falling edge, and directed scenarios with literal expectations.
module tb_dm_port_arbiter;
  localparam int AW = 9;
  localparam int DW = 16;
  localparam int STARVE_MAX = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dm_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dm_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] mem     [0:511];
  logic [DW-1:0] ref_mem [0:511];
  int total = 0;
  int bad   = 0;

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= mem[bus.mem_addr];
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic          m_hold;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  int            m_starve;
  logic          st_valid;
  int            st_who;
  logic [DW-1:0] st_val;
  logic [DW-1:0] exp_p0, exp_p1, exp_ext;
  logic          exp_rvalid;
  int            g;
  logic          g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  logic          e_stall;

  always @(negedge clk) begin
    if (!rst) begin
      m_hold = 0; m_starve = 0; st_valid = 0;
      exp_p0 = 0; exp_p1 = 0; exp_ext = 0; exp_rvalid = 0;
      check_output("rst_stall",  bus.stall,      0);
      check_output("rst_ack",    bus.ext_ack,    0);
      check_output("rst_mem_we", bus.mem_we,     0);
      check_output("rst_p0",     bus.p0_rdata,   0);
      check_output("rst_p1",     bus.p1_rdata,   0);
      check_output("rst_ext",    bus.ext_rdata,  0);
      check_output("rst_rvalid", bus.ext_rvalid, 0);
    end else begin
      g = -1; g_we = 0; g_addr = 0; g_wdata = 0; e_stall = 0;
      if (m_hold) begin
        g = 1; g_we = h_we; g_addr = h_addr; g_wdata = h_wdata;
        m_hold = 0;
      end else if (bus.ext_req && m_starve == STARVE_MAX) begin
        g = 2; g_we = bus.ext_we; g_addr = bus.ext_addr; g_wdata = bus.ext_wdata;
        e_stall = bus.p0_req | bus.p1_req;
      end else if (bus.p0_req && bus.p1_req) begin
        g = 0; g_we = bus.p0_we; g_addr = bus.p0_addr; g_wdata = bus.p0_wdata;
        m_hold = 1; h_we = bus.p1_we; h_addr = bus.p1_addr; h_wdata = bus.p1_wdata;
        e_stall = 1;
      end else if (bus.p0_req) begin
        g = 0; g_we = bus.p0_we; g_addr = bus.p0_addr; g_wdata = bus.p0_wdata;
      end else if (bus.p1_req) begin
        g = 1; g_we = bus.p1_we; g_addr = bus.p1_addr; g_wdata = bus.p1_wdata;
      end else if (bus.ext_req) begin
        g = 2; g_we = bus.ext_we; g_addr = bus.ext_addr; g_wdata = bus.ext_wdata;
      end
      if (g == 2) m_starve = 0;
      else if (bus.ext_req && m_starve < STARVE_MAX) m_starve++;

      check_output("stall",    bus.stall,    e_stall);
      check_output("ext_ack",  bus.ext_ack,  (g == 2));
      check_output("mem_we",   bus.mem_we,   g_we);
      check_output("mem_addr", bus.mem_addr, g_addr);
      if (g_we) check_output("mem_wdata", bus.mem_wdata, g_wdata);
      check_output("p0_rdata",   bus.p0_rdata,   exp_p0);
      check_output("p1_rdata",   bus.p1_rdata,   exp_p1);
      check_output("ext_rdata",  bus.ext_rdata,  exp_ext);
      check_output("ext_rvalid", bus.ext_rvalid, exp_rvalid);

      // Advance: last cycle's read lands now; this cycle's access updates memory.
      exp_rvalid = 0;
      if (st_valid) begin
        case (st_who)
          0: exp_p0 = st_val;
          1: exp_p1 = st_val;
          default: begin exp_ext = st_val; exp_rvalid = 1; end
        endcase
      end
      st_valid = (g >= 0) && !g_we;
      st_who   = g;
      st_val   = ref_mem[g_addr];
      if (g >= 0 && g_we) ref_mem[g_addr] = g_wdata;
    end
  end

  task automatic set_inputs(
    input logic p0r, input logic p0w, input logic [AW-1:0] p0a, input logic [DW-1:0] p0d,
    input logic p1r, input logic p1w, input logic [AW-1:0] p1a, input logic [DW-1:0] p1d,
    input logic er,  input logic ew,  input logic [AW-1:0] ea,  input logic [DW-1:0] ed);
    bus.p0_req = p0r; bus.p0_we = p0w; bus.p0_addr = p0a; bus.p0_wdata = p0d;
    bus.p1_req = p1r; bus.p1_we = p1w; bus.p1_addr = p1a; bus.p1_wdata = p1d;
    bus.ext_req = er; bus.ext_we = ew; bus.ext_addr = ea; bus.ext_wdata = ed;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(
    input logic p0r, input logic p0w, input logic [AW-1:0] p0a, input logic [DW-1:0] p0d,
    input logic p1r, input logic p1w, input logic [AW-1:0] p1a, input logic [DW-1:0] p1d,
    input logic er,  input logic ew,  input logic [AW-1:0] ea,  input logic [DW-1:0] ed);
    set_inputs(p0r, p0w, p0a, p0d, p1r, p1w, p1a, p1d, er, ew, ea, ed);
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus(0,0,0,0, 0,0,0,0, 0,0,0,0);
  endtask

  int ack_at;

  initial begin
    for (int i = 0; i < 512; i++) begin
      mem[i]     = DW'(i) ^ 16'h5A00;
      ref_mem[i] = DW'(i) ^ 16'h5A00;
    end
    mem[9'h010] = 16'h1234; ref_mem[9'h010] = 16'h1234;
    mem[9'h040] = 16'h4040; ref_mem[9'h040] = 16'h4040;
    mem[9'h060] = 16'h6060; ref_mem[9'h060] = 16'h6060;
    mem[9'h070] = 16'h7070; ref_mem[9'h070] = 16'h7070;
    set_inputs(0,0,0,0, 0,0,0,0, 0,0,0,0);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    $display("[TB] scenario 1: lone p0 read");
    apply_stimulus(1,0,9'h010,0, 0,0,0,0, 0,0,0,0);
    idle(1);
    check_output("t1_p0_rdata", bus.p0_rdata, 16'h1234);
    check_output("t1_p1_rdata", bus.p1_rdata, 16'h0000);

    $display("[TB] scenario 2: p0 write / p1 read same address");
    set_inputs(1,1,9'h020,16'hBEEF, 1,0,9'h020,0, 0,0,0,0);
    #1;
    check_output("t2_stall_T", bus.stall, 1);
    check_output("t2_we_T", bus.mem_we, 1);
    step();
    check_output("t2_stall_T1", bus.stall, 0);
    check_output("t2_we_T1", bus.mem_we, 0);
    check_output("t2_addr_T1", bus.mem_addr, 9'h020);
    idle(2);
    check_output("t2_p1_rdata", bus.p1_rdata, 16'hBEEF);

    $display("[TB] scenario 2b: p0 read / p1 write same address");
    apply_stimulus(1,0,9'h020,0, 1,1,9'h020,16'h5555, 0,0,0,0);
    step();
    idle(2);
    check_output("t2b_p0_old", bus.p0_rdata, 16'hBEEF);
    check_output("t2b_mem", mem[9'h020], 16'h5555);

    $display("[TB] scenario 3: double write same address");
    set_inputs(1,1,9'h030,16'h1111, 1,1,9'h030,16'h2222, 0,0,0,0);
    #1;
    check_output("t3_wdata_T", bus.mem_wdata, 16'h1111);
    step();
    check_output("t3_we_T1", bus.mem_we, 1);
    check_output("t3_wdata_T1", bus.mem_wdata, 16'h2222);
    idle(1);
    check_output("t3_mem", mem[9'h030], 16'h2222);

    $display("[TB] scenario 4: ext starvation");
    ack_at = -1;
    set_inputs(1,0,9'h060,0, 0,0,0,0, 1,0,9'h040,0);
    for (int i = 1; i <= 8 && ack_at < 0; i++) begin
      #1;
      if (bus.ext_ack === 1'b1) begin
        ack_at = i;
        check_output("t4_stall", bus.stall, 1);
        check_output("t4_addr", bus.mem_addr, 9'h040);
      end
      step();
    end
    check_output("t4_ack_cycle", ack_at, 5);
    set_inputs(1,0,9'h060,0, 0,0,0,0, 0,0,0,0);
    #1;
    check_output("t4_p0_addr", bus.mem_addr, 9'h060);
    check_output("t4_rvalid", bus.ext_rvalid, 0);
    step();
    check_output("t4_rvalid_pulse", bus.ext_rvalid, 1);
    check_output("t4_ext_rdata", bus.ext_rdata, 16'h4040);
    idle(2);
    check_output("t4_p0_rdata", bus.p0_rdata, 16'h6060);

    $display("[TB] scenario 5: reset during held p1 write");
    apply_stimulus(1,0,9'h070,0, 1,1,9'h070,16'hDEAD, 0,0,0,0);
    rst = 1'b0;
    #1;
    check_output("t5_stall", bus.stall, 0);
    check_output("t5_mem_we", bus.mem_we, 0);
    check_output("t5_mem_addr", bus.mem_addr, 0);
    check_output("t5_p0_rdata", bus.p0_rdata, 0);
    set_inputs(0,0,0,0, 0,0,0,0, 0,0,0,0);
    step();
    step();
    rst = 1'b1;
    step();
    check_output("t5_mem_kept", mem[9'h070], 16'h7070);
    set_inputs(0,0,0,0, 1,0,9'h070,0, 0,0,0,0);
    #1;
    check_output("t5_idle_stall", bus.stall, 0);
    check_output("t5_idle_addr", bus.mem_addr, 9'h070);
    step();
    idle(2);
    check_output("t5_p1_rdata", bus.p1_rdata, 16'h7070);

    $display("[TB] scenario 6: ext write");
    set_inputs(0,0,0,0, 0,0,0,0, 1,1,9'h050,16'hCAFE);
    #1;
    check_output("t6_ack", bus.ext_ack, 1);
    check_output("t6_we", bus.mem_we, 1);
    step();
    set_inputs(0,0,0,0, 0,0,0,0, 0,0,0,0);
    check_output("t6_rvalid_a", bus.ext_rvalid, 0);
    step();
    check_output("t6_rvalid_b", bus.ext_rvalid, 0);
    check_output("t6_mem", mem[9'h050], 16'hCAFE);
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
